// File: rtl/zhengxing_pkg.sv
// ============================================================================
// Module : zhengxing_pkg
// Brief  : Shared state encoding and threshold helper for the square-wave shaper
// Rev    : 1.0 - initial multi-channel hysteresis release
// ============================================================================
`default_nettype none

package zhengxing_pkg;

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_RISE_PEND = 2'd1,
        S_HIGH      = 2'd2,
        S_FALL_PEND = 2'd3
    } state_e;

    localparam logic [1:0] C_ST_LOW       = 2'(S_LOW);
    localparam logic [1:0] C_ST_RISE_PEND = 2'(S_RISE_PEND);
    localparam logic [1:0] C_ST_HIGH      = 2'(S_HIGH);
    localparam logic [1:0] C_ST_FALL_PEND = 2'(S_FALL_PEND);

    typedef struct packed {
        logic [31:0] up;
        logic [31:0] dn;
    } thr_t;

    // Band edges saturate at the DW-bit range instead of wrapping.
    function automatic thr_t thr_calc(input logic [31:0] yuzhi,
                                      input logic [31:0] hyst,
                                      input int          dw);
        logic [32:0] w_sum;
        logic [32:0] w_lim;
        thr_t        w_res;
        w_sum    = {1'b0, yuzhi} + {1'b0, hyst};
        w_lim    = (33'd1 << dw) - 33'd1;
        w_res.up = (w_sum > w_lim) ? w_lim[31:0] : w_sum[31:0];
        w_res.dn = (yuzhi >= hyst) ? (yuzhi - hyst) : 32'd0;
        return w_res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/zhengxing_ch.sv
// ============================================================================
// Module : zhengxing_ch
// Brief  : One shaper channel - hysteresis compare, debounce FSM, edge strobes
// Rev    : 1.0 - initial multi-channel hysteresis release
// ============================================================================
`default_nettype none

module zhengxing_ch
    import zhengxing_pkg::*;
#(
    parameter int DW    = 12,
    parameter int DEB_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    data_in,
    input  logic [DW-1:0]    yuzhi,
    input  logic [DW-1:0]    hyst,
    input  logic [DEB_W-1:0] deb_len,
    input  logic             data_valid,
    output logic             fangbo,
    output logic             rise_pulse,
    output logic             fall_pulse
);

    thr_t             w_thr;
    logic [DW-1:0]    w_up;
    logic [DW-1:0]    w_dn;
    logic             w_unused_thr;
    logic             w_hi;
    logic             w_lo;
    logic [1:0]       w_state_nxt;
    logic [DEB_W-1:0] w_cnt_nxt;
    logic             w_fb_nxt;

    logic [1:0]       r_state;
    logic [DEB_W-1:0] r_cnt;
    logic             r_fangbo;
    logic             r_rise;
    logic             r_fall;

    assign w_thr        = thr_calc(32'(yuzhi), 32'(hyst), DW);
    assign w_up         = w_thr.up[DW-1:0];
    assign w_dn         = w_thr.dn[DW-1:0];
    assign w_unused_thr = ^{w_thr.up[31:DW], w_thr.dn[31:DW]};
    assign w_hi         = (data_in >= w_up);
    assign w_lo         = (data_in <  w_dn);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            C_ST_LOW: begin
                if (w_hi) begin
                    w_state_nxt = (deb_len == '0) ? C_ST_HIGH : C_ST_RISE_PEND;
                    w_cnt_nxt   = (deb_len == '0) ? '0 : DEB_W'(1);
                end
            end
            C_ST_RISE_PEND: begin
                if (!w_hi) begin
                    w_state_nxt = C_ST_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == deb_len) begin
                    w_state_nxt = C_ST_HIGH;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + DEB_W'(1);
                end
            end
            C_ST_HIGH: begin
                if (w_lo) begin
                    w_state_nxt = (deb_len == '0) ? C_ST_LOW : C_ST_FALL_PEND;
                    w_cnt_nxt   = (deb_len == '0) ? '0 : DEB_W'(1);
                end
            end
            default: begin
                if (!w_lo) begin
                    w_state_nxt = C_ST_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == deb_len) begin
                    w_state_nxt = C_ST_LOW;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + DEB_W'(1);
                end
            end
        endcase
    end

    // The output is high in HIGH and FALL_PEND, i.e. the state MSB.
    assign w_fb_nxt = w_state_nxt[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= C_ST_LOW;
            r_cnt    <= '0;
            r_fangbo <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else if (!data_valid) begin
            // Forced idle clear: silent, no fall strobe.
            r_state  <= C_ST_LOW;
            r_cnt    <= '0;
            r_fangbo <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_fangbo <= w_fb_nxt;
            r_rise   <= w_fb_nxt & ~r_fangbo;
            r_fall   <= ~w_fb_nxt & r_fangbo;
        end
    end

    assign fangbo     = r_fangbo;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;

endmodule

`default_nettype wire

// File: rtl/zhengxing_hyst.sv
// ============================================================================
// Module : zhengxing_hyst
// Brief  : NCH-channel hysteresis/debounce square-wave shaper with edge strobes
// Rev    : 1.0 - initial multi-channel hysteresis release
// ============================================================================
`default_nettype none

module zhengxing_hyst
    import zhengxing_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int DW    = 12,
    parameter int DEB_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*DW-1:0] data_in,
    input  logic [NCH*DW-1:0] data_yuzhi,
    input  logic [DW-1:0]     hyst,
    input  logic [DEB_W-1:0]  deb_len,
    input  logic              data_valid,
    output logic [NCH-1:0]    fangbo,
    output logic [NCH-1:0]    rise_pulse,
    output logic [NCH-1:0]    fall_pulse
);

    genvar k;
    generate
        for (k = 0; k < NCH; k++) begin : g_ch
            zhengxing_ch #(
                .DW    (DW),
                .DEB_W (DEB_W)
            ) u_ch (
                .clk        (clk),
                .rst        (rst),
                .data_in    (data_in[k*DW +: DW]),
                .yuzhi      (data_yuzhi[k*DW +: DW]),
                .hyst       (hyst),
                .deb_len    (deb_len),
                .data_valid (data_valid),
                .fangbo     (fangbo[k]),
                .rise_pulse (rise_pulse[k]),
                .fall_pulse (fall_pulse[k])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_zhengxing_hyst.sv
// ============================================================================
// Module : tb_zhengxing_hyst
// Brief  : Directed self-checking bench for the 4-channel shaper
// Rev    : 1.0 - initial
// ============================================================================
`default_nettype none

module tb_zhengxing_hyst;

    localparam int NCH   = 4;
    localparam int DW    = 12;
    localparam int DEB_W = 8;

    logic              clk;
    logic              rst;
    logic [NCH*DW-1:0] data_in;
    logic [NCH*DW-1:0] data_yuzhi;
    logic [DW-1:0]     hyst;
    logic [DEB_W-1:0]  deb_len;
    logic              data_valid;
    logic [NCH-1:0]    fangbo;
    logic [NCH-1:0]    rise_pulse;
    logic [NCH-1:0]    fall_pulse;

    int checks = 0;
    int errors = 0;

    zhengxing_hyst #(
        .NCH   (NCH),
        .DW    (DW),
        .DEB_W (DEB_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_yuzhi (data_yuzhi),
        .hyst       (hyst),
        .deb_len    (deb_len),
        .data_valid (data_valid),
        .fangbo     (fangbo),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check all three output vectors at once.
    task automatic chk_out(input string tag, input logic [NCH-1:0] fb,
                           input logic [NCH-1:0] rp, input logic [NCH-1:0] fp);
        chk({tag, ".fangbo"}, 32'(fangbo), 32'(fb));
        chk({tag, ".rise"},   32'(rise_pulse), 32'(rp));
        chk({tag, ".fall"},   32'(fall_pulse), 32'(fp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input int k, input int v);
        data_in[k*DW +: DW] = DW'(v);
    endtask

    task automatic set_y(input int k, input int v);
        data_yuzhi[k*DW +: DW] = DW'(v);
    endtask

    initial begin
        rst        = 1'b0;
        data_valid = 1'b1;
        hyst       = '0;
        deb_len    = '0;
        data_in    = '0;
        for (int k = 0; k < NCH; k++) set_y(k, 2048);
        set_d(0, 2040);

        // Reset state
        step();
        step();
        chk_out("reset", 4'b0000, 4'b0000, 4'b0000);
        @(negedge clk);
        rst = 1'b1;

        // 1. Legacy ramp on ch0: hyst=0, deb_len=0
        for (int v = 2040; v <= 2056; v++) begin
            set_d(0, v);
            step();
            chk_out($sformatf("ramp%0d", v), (v >= 2048) ? 4'b0001 : 4'b0000,
                    (v == 2048) ? 4'b0001 : 4'b0000, 4'b0000);
        end
        set_d(0, 0);
        step();
        chk_out("legacy_fall", 4'b0000, 4'b0000, 4'b0001);
        step();
        chk_out("legacy_fall_end", 4'b0000, 4'b0000, 4'b0000);

        // 2. Hysteresis: up=2148, dn=1948
        hyst = 12'd100;
        for (int i = 0; i < 4; i++) begin
            set_d(0, (i % 2 == 0) ? 2000 : 2100);
            step();
            chk_out($sformatf("band%0d", i), 4'b0000, 4'b0000, 4'b0000);
        end
        set_d(0, 2148);
        step();
        chk_out("hyst_rise", 4'b0001, 4'b0001, 4'b0000);
        set_d(0, 2000);
        step();
        chk_out("hyst_hold", 4'b0001, 4'b0000, 4'b0000);
        set_d(0, 1947);
        step();
        chk_out("hyst_fall", 4'b0000, 4'b0000, 4'b0001);
        step();
        chk_out("hyst_fall_end", 4'b0000, 4'b0000, 4'b0000);

        // 3. Debounce deb_len=3: 3-sample glitch rejected, 4 samples commit
        hyst    = '0;
        deb_len = 8'd3;
        for (int i = 0; i < 3; i++) begin
            set_d(0, 3000);
            step();
            chk_out($sformatf("glitch%0d", i), 4'b0000, 4'b0000, 4'b0000);
        end
        set_d(0, 0);
        step();
        chk_out("glitch_end", 4'b0000, 4'b0000, 4'b0000);
        set_d(0, 3000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("deb_pend%0d", i), 4'b0000, 4'b0000, 4'b0000);
        end
        step();
        chk_out("deb_rise", 4'b0001, 4'b0001, 4'b0000);
        step();
        chk_out("deb_hold", 4'b0001, 4'b0000, 4'b0000);
        deb_len = '0;
        set_d(0, 0);
        step();
        chk_out("deb0_fall", 4'b0000, 4'b0000, 4'b0001);

        // 4. Saturation on ch1: yuzhi=4090, hyst=50 -> up=4095
        hyst = 12'd50;
        set_y(1, 4090);
        set_d(1, 4094);
        step();
        chk_out("sat_below", 4'b0000, 4'b0000, 4'b0000);
        set_d(1, 4095);
        step();
        chk_out("sat_rise", 4'b0010, 4'b0010, 4'b0000);
        // yuzhi=10 -> dn=0, nothing is below 0
        set_y(1, 10);
        set_d(1, 0);
        step();
        step();
        chk_out("sat_nofall", 4'b0010, 4'b0000, 4'b0000);

        // 5a. data_valid drop while HIGH: silent clear
        data_valid = 1'b0;
        step();
        chk_out("dv_drop_high", 4'b0000, 4'b0000, 4'b0000);
        data_valid = 1'b1;
        step();
        chk_out("dv_restore", 4'b0000, 4'b0000, 4'b0000);

        // 5b. data_valid drop mid-RISE_PEND clears the counter
        hyst    = '0;
        deb_len = 8'd3;
        set_y(1, 2048);
        set_d(1, 3000);
        step();
        step();
        data_valid = 1'b0;
        step();
        chk_out("dv_drop_pend", 4'b0000, 4'b0000, 4'b0000);
        data_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("dv_repend%0d", i), 4'b0000, 4'b0000, 4'b0000);
        end
        step();
        chk_out("dv_rerise", 4'b0010, 4'b0010, 4'b0000);

        // 5c. Async reset mid-pend on ch2 while ch1 is HIGH
        set_d(2, 3000);
        step();
        step();
        #3;
        rst = 1'b0;
        #1;
        chk_out("async_rst", 4'b0000, 4'b0000, 4'b0000);
        data_in = '0;
        deb_len = '0;
        @(negedge clk);
        rst = 1'b1;
        step();
        chk_out("post_rst", 4'b0000, 4'b0000, 4'b0000);

        // 6. Independence: staggered and simultaneous edges
        set_y(0, 1000);
        set_y(1, 2000);
        set_y(2, 3000);
        set_y(3, 500);
        set_d(0, 1000); set_d(3, 600);
        step();
        chk_out("ind_a", 4'b1001, 4'b1001, 4'b0000);
        set_d(1, 2500); set_d(2, 3500);
        step();
        chk_out("ind_b", 4'b1111, 4'b0110, 4'b0000);
        set_d(0, 999);
        step();
        chk_out("ind_c", 4'b1110, 4'b0000, 4'b0001);
        set_d(0, 1000); set_d(1, 0); set_d(2, 0); set_d(3, 499);
        step();
        chk_out("ind_d", 4'b0001, 4'b0001, 4'b1110);
        step();
        chk_out("ind_e", 4'b0001, 4'b0000, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
